// File: rtl/gf_dlog_seq.sv
// -----------------------------------------------------------------------------
// gf_dlog_seq
//
// Sequential discrete-logarithm engine for GF(2^SIZE). Given a field element y
// it returns the exponent k (0..m-1) such that alpha^k == y, with alpha = 0x02.
// No log table is used: the engine starts from alpha^0 = 1 and repeatedly
// multiplies by alpha (xtime) until the running power equals y. The result is
// used to cross-check exp/log tables and to recover error-locator exponents in
// the RS decoder path.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_valid   request valid; y is sampled while in_ready is high
//   in_ready   engine idle and able to take a request
//   y          element whose logarithm is requested
//   out_valid  result available (held until out_ready)
//   out_ready  consumer takes the result
//   log_out    exponent k with alpha^k == y (0 when err is set)
//   err        log undefined (y == 0) or no match within m steps
//   busy       search in progress
//
// Timing (edges counted inclusively from the accepting edge):
//   y != 0 : out_valid is high after edge k+2
//   y == 0 : out_valid is high after edge 1
// Only one request is in flight; a new one is taken only after the previous
// result has been consumed.
// -----------------------------------------------------------------------------
module gf_dlog_seq #(
    parameter int              m    = 255,
    parameter int              SIZE = $clog2(m),
    parameter logic [SIZE-1:0] POLY = 8'h1D
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] log_out,
    output logic            err,
    output logic            busy
);

    // Last exponent that is still inside the multiplicative group.
    localparam logic [SIZE-1:0] K_LAST = SIZE'(m - 1);
    localparam logic [SIZE-1:0] ZERO_E = {SIZE{1'b0}};
    localparam logic [SIZE-1:0] ONE_E  = {{(SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Multiply a field element by alpha: shift left and fold the carry-out
    // back in through the low bits of the primitive polynomial.
    function automatic logic [SIZE-1:0] xtime(input logic [SIZE-1:0] a);
        logic [SIZE-1:0] shifted;
        shifted = {a[SIZE-2:0], 1'b0};
        if (a[SIZE-1]) begin
            xtime = shifted ^ POLY;
        end else begin
            xtime = shifted;
        end
    endfunction

    state_t          state_r, state_s;
    logic [SIZE-1:0] y_r,   y_s;      // requested element
    logic [SIZE-1:0] acc_r, acc_s;    // alpha^k_r
    logic [SIZE-1:0] k_r,   k_s;      // current exponent under test
    logic [SIZE-1:0] log_r, log_s;    // result exponent
    logic            err_r, err_s;    // result error flag

    // Next-state and datapath decode for the IDLE / SEARCH / DONE sequencer.
    always_comb begin
        state_s = state_r;
        y_s     = y_r;
        acc_s   = acc_r;
        k_s     = k_r;
        log_s   = log_r;
        err_s   = err_r;

        case (state_r)
            ST_IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone accepts.
                if (in_valid) begin
                    y_s = y;
                    if (y == ZERO_E) begin
                        // log(0) is undefined: answer immediately.
                        log_s   = ZERO_E;
                        err_s   = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        acc_s   = ONE_E;
                        k_s     = ZERO_E;
                        state_s = ST_SEARCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SEARCH: begin
                if (acc_r == y_r) begin
                    log_s   = k_r;
                    err_s   = 1'b0;
                    state_s = ST_DONE;
                end else if (k_r == K_LAST) begin
                    // Only reachable with a non-primitive POLY; keeps the
                    // search bounded regardless of the parameter choice.
                    log_s   = ZERO_E;
                    err_s   = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    acc_s   = xtime(acc_r);
                    k_s     = k_r + ONE_E;
                    state_s = ST_SEARCH;
                end
            end

            ST_DONE: begin
                // log_r / err_r are untouched here, so they stay stable under
                // backpressure.
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            y_r     <= ZERO_E;
            acc_r   <= ONE_E;
            k_r     <= ZERO_E;
            log_r   <= ZERO_E;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            y_r     <= y_s;
            acc_r   <= acc_s;
            k_r     <= k_s;
            log_r   <= log_s;
            err_r   <= err_s;
        end
    end

    // Handshake flags come straight from the state register; result data come
    // from registers, so nothing on the outputs depends combinationally on
    // the inputs.
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r == ST_SEARCH);
    assign log_out   = log_r;
    assign err       = err_r;

endmodule
